// File: rtl/tm1638_hex_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_hex_feeder
// Purpose  : Turns a 32-bit hex value, plus per-digit decimal-point and blank
//            flags, into eight wr/mask/data digit writes for the TM1638
//            display driver. Refreshes are rate-limited by a holdoff period.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_hex_feeder #(
  parameter bit          AUTO          = 1'b1,
  parameter int unsigned HOLDOFF_TICKS = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        update,
  output logic        busy,
  output logic        wr,
  output logic [7:0]  mask,
  output logic [7:0]  data
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_WR_HI   = 2'd1;
  localparam logic [1:0]  S_WR_LO   = 2'd2;
  localparam logic [1:0]  S_HOLD    = 2'd3;
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_TICKS);

  logic [1:0]  state;
  logic [2:0]  digit;
  logic [15:0] hold_cnt;
  logic        pending;
  logic [31:0] snap_value;
  logic [7:0]  snap_dp;
  logic [7:0]  snap_blank;
  logic        mismatch;
  logic        trigger;

  // Hex nibble to segment byte (D7 DP, D6 a, D5 b, D4 c, D3 e, D2 g, D1 f, D0 d).
  function automatic logic [7:0] seg_enc(input logic [3:0] nib, input logic pt, input logic blk);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h7B;
      4'h1: s = 8'h30;
      4'h2: s = 8'h6D;
      4'h3: s = 8'h75;
      4'h4: s = 8'h36;
      4'h5: s = 8'h57;
      4'h6: s = 8'h5F;
      4'h7: s = 8'h70;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h77;
      4'hA: s = 8'h7E;
      4'hB: s = 8'h1F;
      4'hC: s = 8'h4B;
      4'hD: s = 8'h3D;
      4'hE: s = 8'h4F;
      default: s = 8'h4E;
    endcase
    if (blk) begin
      return 8'h00;
    end
    return s | {pt, 7'b0};
  endfunction

  // Segment byte for digit idx, where idx 0 is the leftmost digit (value[31:28], bit 7 of dp/blank).
  function automatic logic [7:0] digit_byte(input logic [31:0] v, input logic [7:0] p,
                                            input logic [7:0] b, input logic [2:0] idx);
    logic [2:0] pos;
    pos = 3'd7 - idx;
    return seg_enc(v[{pos, 2'b00} +: 4], p[pos], b[pos]);
  endfunction

  // Refresh request: explicit update, a deferred request, or (AUTO) inputs differ from what was last sent.
  always_comb begin
    mismatch = AUTO && ({value, dp, blank} != {snap_value, snap_dp, snap_blank});
    trigger  = update || pending || mismatch;
  end

  // Sequencer: snapshot at start, eight strobed digit writes, then a clken-timed holdoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      digit      <= 3'd0;
      hold_cnt   <= 16'd0;
      pending    <= 1'b1;
      snap_value <= 32'd0;
      snap_dp    <= 8'd0;
      snap_blank <= 8'd0;
      busy       <= 1'b0;
      wr         <= 1'b0;
      mask       <= 8'h00;
      data       <= 8'h00;
    end else begin
      // Updates arriving while busy are remembered and coalesce into one refresh.
      if (state != S_IDLE && update) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (trigger) begin
            snap_value <= value;
            snap_dp    <= dp;
            snap_blank <= blank;
            pending    <= 1'b0;
            digit      <= 3'd0;
            wr         <= 1'b1;
            mask       <= 8'h80;
            data       <= digit_byte(value, dp, blank, 3'd0);
            busy       <= 1'b1;
            state      <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          wr    <= 1'b0;
          state <= S_WR_LO;
        end
        S_WR_LO: begin
          if (digit != 3'd7) begin
            digit <= digit + 3'd1;
            wr    <= 1'b1;
            mask  <= mask >> 1;
            data  <= digit_byte(snap_value, snap_dp, snap_blank, digit + 3'd1);
            state <= S_WR_HI;
          end else begin
            hold_cnt <= HOLD_LOAD;
            mask     <= 8'h00;
            data     <= 8'h00;
            state    <= S_HOLD;
          end
        end
        default: begin
          if (clken) begin
            if (hold_cnt == 16'd1) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tm1638_hex_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_hex_feeder
// Purpose  : Directed bench for tm1638_hex_feeder; instance a runs with
//            AUTO=1, instance b with AUTO=0, both with a 3-tick holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_hex_feeder;

  localparam int HOLD_N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_clken, a_update, a_busy, a_wr;
  logic [31:0] a_value;
  logic [7:0]  a_dp, a_blank, a_mask, a_data;
  logic        b_reset, b_clken, b_update, b_busy, b_wr;
  logic [31:0] b_value;
  logic [7:0]  b_dp, b_blank, b_mask, b_data;

  tm1638_hex_feeder #(.AUTO(1'b1), .HOLDOFF_TICKS(HOLD_N)) dut_a (
    .clk(clk), .reset(a_reset), .clken(a_clken), .value(a_value), .dp(a_dp),
    .blank(a_blank), .update(a_update), .busy(a_busy), .wr(a_wr), .mask(a_mask), .data(a_data)
  );

  tm1638_hex_feeder #(.AUTO(1'b0), .HOLDOFF_TICKS(HOLD_N)) dut_b (
    .clk(clk), .reset(b_reset), .clken(b_clken), .value(b_value), .dp(b_dp),
    .blank(b_blank), .update(b_update), .busy(b_busy), .wr(b_wr), .mask(b_mask), .data(b_data)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int a_pulses = 0;
  int b_pulses = 0;

  // Each wr pulse is one clock wide, so it is seen high at exactly one falling edge.
  always @(negedge clk) begin
    if (a_wr === 1'b1) a_pulses <= a_pulses + 1;
    if (b_wr === 1'b1) b_pulses <= b_pulses + 1;
  end

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'h7B; 4'h1: seg = 8'h30; 4'h2: seg = 8'h6D; 4'h3: seg = 8'h75;
      4'h4: seg = 8'h36; 4'h5: seg = 8'h57; 4'h6: seg = 8'h5F; 4'h7: seg = 8'h70;
      4'h8: seg = 8'h7F; 4'h9: seg = 8'h77; 4'hA: seg = 8'h7E; 4'hB: seg = 8'h1F;
      4'hC: seg = 8'h4B; 4'hD: seg = 8'h3D; 4'hE: seg = 8'h4F; default: seg = 8'h4E;
    endcase
  endfunction

  function automatic logic get_wr(input bit sel);
    return sel ? b_wr : a_wr;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction
  function automatic logic [7:0] get_mask(input bit sel);
    return sel ? b_mask : a_mask;
  endfunction
  function automatic logic [7:0] get_data(input bit sel);
    return sel ? b_data : a_data;
  endfunction

  task automatic set_clken(input bit sel, input logic v);
    if (sel) b_clken = v;
    else     a_clken = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects eight back-to-back pulses (leftmost first); exp holds data bytes, digit 0 in bits 63:56.
  task automatic run_seq(input bit sel, input logic [63:0] exp, input int first_bound, input string tag);
    int n;
    logic [7:0] em;
    logic [7:0] ed;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (get_wr(sel) !== 1'b1 && n < ((i == 0) ? first_bound : 1)) begin
        @(negedge clk);
        n++;
      end
      em = 8'h80 >> i;
      ed = exp[63-8*i -: 8];
      chk($sformatf("%s_wr_hi%0d", tag, i), 32'(get_wr(sel)), 32'h1);
      chk($sformatf("%s_mask%0d", tag, i), 32'(get_mask(sel)), 32'(em));
      chk($sformatf("%s_data%0d", tag, i), 32'(get_data(sel)), 32'(ed));
      chk($sformatf("%s_busy%0d", tag, i), 32'(get_busy(sel)), 32'h1);
      @(negedge clk);
      chk($sformatf("%s_wr_lo%0d", tag, i), 32'(get_wr(sel)), 32'h0);
      chk($sformatf("%s_mask_hold%0d", tag, i), 32'(get_mask(sel)), 32'(em));
      chk($sformatf("%s_data_hold%0d", tag, i), 32'(get_data(sel)), 32'(ed));
    end
  endtask

  // Called right after the last pulse's low cycle; checks holdoff lasts exactly HOLD_N clken ticks.
  task automatic hold_check(input bit sel, input string tag);
    @(negedge clk);
    chk({tag, "_mask0"}, 32'(get_mask(sel)), 32'h0);
    chk({tag, "_data0"}, 32'(get_data(sel)), 32'h0);
    for (int k = 0; k < HOLD_N; k++) begin
      chk($sformatf("%s_busy_before_tick%0d", tag, k), 32'(get_busy(sel)), 32'h1);
      set_clken(sel, 1'b1);
      @(negedge clk);
      set_clken(sel, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_busy_fall"}, 32'(get_busy(sel)), 32'h0);
  endtask

  initial begin
    int         cnt;
    int         base;
    bit         seen;
    bit         ok;
    logic [3:0] nib;
    logic [7:0] exp_d;

    a_reset = 1'b1; a_clken = 1'b0; a_update = 1'b0;
    a_value = 32'h0123ABCD; a_dp = 8'h00; a_blank = 8'h00;
    b_reset = 1'b1; b_clken = 1'b0; b_update = 1'b0;
    b_value = 32'h89ABCDEF; b_dp = 8'h00; b_blank = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr", 32'(a_wr), 32'h0);
    chk("rst_mask", 32'(a_mask), 32'h0);
    chk("rst_data", 32'(a_data), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);

    // Refresh right after reset release
    @(negedge clk);
    a_reset = 1'b0;
    run_seq(1'b0, 64'h7B306D757E1F4B3D, 3, "t1");
    hold_check(1'b0, "t1_hold");
    repeat (5) @(negedge clk);
    chk("t1_pulse_count", 32'(a_pulses), 32'd8);
    chk("t1_idle_busy", 32'(a_busy), 32'h0);

    // AUTO refresh on value change
    a_value = 32'hFFFFFFFF;
    run_seq(1'b0, {8{8'h4E}}, 2, "t2");
    hold_check(1'b0, "t2_hold");

    // Decimal points and blanking
    a_dp = 8'h81; a_blank = 8'h18; a_value = 32'h88888888;
    run_seq(1'b0, 64'hFF7F7F00007F7FFF, 2, "t3");
    hold_check(1'b0, "t3_hold");

    // Value changing every clock: one consistent sequence per holdoff period
    a_dp = 8'h00; a_blank = 8'h00;
    nib = 4'h0;
    for (int p = 0; p < 3; p++) begin
      seen = 1'b0; cnt = 0; ok = 1'b1; exp_d = 8'h00;
      for (int c = 0; c < 100; c++) begin
        if (a_busy === 1'b1) seen = 1'b1;
        if (seen && a_busy === 1'b0) break;
        if (a_wr === 1'b1) begin
          if (cnt == 0) exp_d = seg(nib);
          if (cnt > 7) ok = 1'b0;
          else if (a_mask !== (8'h80 >> cnt) || a_data !== exp_d) ok = 1'b0;
          cnt++;
        end
        nib = nib + 4'h1;
        a_value = {8{nib}};
        a_clken = (c % 4 == 0);
        @(negedge clk);
      end
      chk($sformatf("t4_pulses_p%0d", p), 32'(cnt), 32'd8);
      chk($sformatf("t4_consistent_p%0d", p), 32'(ok), 32'h1);
      chk($sformatf("t4_period_end_p%0d", p), 32'(seen && a_busy === 1'b0), 32'h1);
    end

    // Reset in the middle of a sequence
    a_clken = 1'b0;
    a_value = 32'h0123ABCD;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      if (a_wr === 1'b1) cnt++;
    end
    a_reset = 1'b1;
    #1;
    chk("t5_pulses_before_rst", 32'(cnt), 32'd4);
    chk("t5_rst_wr", 32'(a_wr), 32'h0);
    chk("t5_rst_mask", 32'(a_mask), 32'h0);
    chk("t5_rst_data", 32'(a_data), 32'h0);
    chk("t5_rst_busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    a_reset = 1'b0;
    run_seq(1'b0, 64'h7B306D757E1F4B3D, 3, "t5");
    hold_check(1'b0, "t5_hold");

    // update together with an AUTO mismatch gives a single refresh
    a_value = 32'hFFFFFFFF;
    a_update = 1'b1;
    @(negedge clk);
    a_update = 1'b0;
    run_seq(1'b0, {8{8'h4E}}, 1, "t6");
    hold_check(1'b0, "t6_hold");
    base = a_pulses;
    repeat (6) @(negedge clk);
    chk("t6_single_refresh", 32'(a_pulses), 32'(base));

    // AUTO=0 instance: initial refresh after reset
    @(negedge clk);
    b_reset = 1'b0;
    run_seq(1'b1, 64'h7F777E1F4B3D4F4E, 3, "b1");
    @(negedge clk);
    chk("b1_hold_busy", 32'(b_busy), 32'h1);
    // Three updates during holdoff, with a new value
    b_value = 32'h76543210;
    b_update = 1'b1; b_clken = 1'b1;
    @(negedge clk);
    b_update = 1'b0; b_clken = 1'b0;
    @(negedge clk);
    b_update = 1'b1;
    @(negedge clk);
    b_update = 1'b0; b_clken = 1'b1;
    @(negedge clk);
    b_clken = 1'b0; b_update = 1'b1;
    @(negedge clk);
    b_update = 1'b0;
    chk("b1_busy_two_ticks", 32'(b_busy), 32'h1);
    b_clken = 1'b1;
    @(negedge clk);
    b_clken = 1'b0;
    chk("b1_busy_fall", 32'(b_busy), 32'h0);
    run_seq(1'b1, 64'h705F5736756D307B, 2, "b2");
    hold_check(1'b1, "b2_hold");
    // Input change with no update: no writes
    base = b_pulses;
    b_value = 32'hFEDCBA98;
    repeat (8) @(negedge clk);
    chk("b_no_auto_pulses", 32'(b_pulses), 32'(base));
    chk("b_no_auto_busy", 32'(b_busy), 32'h0);
    // update while idle starts a refresh with the current inputs
    b_update = 1'b1;
    @(negedge clk);
    b_update = 1'b0;
    run_seq(1'b1, 64'h4E4F3D4B1F7E777F, 1, "b3");
    hold_check(1'b1, "b3_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm1638_hex_feeder.md
Name: tm1638_hex_feeder

Overview:
- Upstream feeder for the TM1638 display driver.
- Takes a 32-bit value plus per-digit decimal-point and blank flags, and encodes each nibble into the driver's segment bit map.
- Issues one write-strobe/mask/data transfer per digit (8 per refresh) on the driver's wr/mask/data interface.
- Rate-limits refreshes so a fast-changing value (e.g. a live SC/MP address bus) cannot keep the serial link permanently busy.

Parameters:
- AUTO, 1, 1 = refresh automatically when value/dp/blank differ from the last-sent snapshot; 0 = refresh only on update.
- HOLDOFF_TICKS, 20000, clken ticks of enforced idle after a refresh completes (20 ms at 1 MHz); legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clken  in  1  1 MHz tick enable; used only by the holdoff counter
- value  in  32  hex value; value[31:28] is shown on the leftmost digit
- dp  in  8  decimal point per digit; bit 7 = leftmost digit
- blank  in  8  blank per digit; bit 7 = leftmost digit; overrides value and dp
- update  in  1  single-cycle request to refresh now; sampled every clk
- busy  out  1  high while a refresh sequence or holdoff is in progress
- wr  out  1  to driver: write strobe; the driver acts on the rising edge
- mask  out  8  to driver: one-hot digit select; bit 7 = leftmost digit
- data  out  8  to driver: segment byte, active-high; D7 DP, D6 a, D5 b, D4 c, D3 e, D2 g, D1 f, D0 d

Behaviour:
- All outputs registered. Reset values: wr=0, mask=0x00, data=0x00, busy=0. Snapshot registers clear to 0. pending=1 at reset, so a refresh showing the current inputs starts right after reset deasserts.
- Segment encoding, nibble 0..F:
  - 0-7: 7B 30 6D 75 36 57 5F 70
  - 8-F: 7F 77 7E 1F 4B 3D 4F 4E
  - dp adds 0x80; blank forces 0x00.
- States: IDLE, WR_HI, WR_LO, HOLD. Digit counter d runs 0..7.
- IDLE:
  - Trigger = update, or pending, or (AUTO and {value,dp,blank} != snapshot).
  - On trigger: latch inputs into the snapshot, clear pending, d=0, go to WR_HI.
  - Next cycle: wr=1, mask=0x80>>d, data=enc(digit d of snapshot), busy=1.
- WR_HI (1 clk): wr high. Next state WR_LO with wr=0; mask and data hold.
- WR_LO (1 clk):
  - d<7: d++, go to WR_HI.
  - d==7: go to HOLD, load holdoff counter with HOLDOFF_TICKS, mask=0x00, data=0x00.
- Sequence length: 16 clk from the first wr rising edge to HOLD entry. Writes always go leftmost first; each wr pulse is exactly 1 clk high, with at least 1 clk low between pulses.
- HOLD:
  - Counter decrements on clken only. When it reaches 0, return to IDLE and set busy=0 in the same transition.
  - An IDLE trigger can start the next sequence on the following clk.
- update while busy: sets pending; acted on in IDLE after HOLD. Multiple updates coalesce into one refresh.
- AUTO: input changes during busy are not tracked. On IDLE re-entry the comparison against the snapshot decides. The displayed data is always taken from the snapshot latched at sequence start; mid-sequence input changes never mix into a refresh.
- update and an AUTO mismatch in the same cycle: one refresh only.
- reset mid-sequence: outputs return to reset values immediately. pending=1 forces a full fresh sequence after release; a partial wr train is never resumed.
- clken during WR_HI/WR_LO: ignored.

Test Plan:
- Release reset with value=0x0123ABCD, dp=0, blank=0 -> 8 wr pulses, masks 80,40,...,01; data 7B,30,6D,75,7E,1F,4B,3D; busy=1; busy falls HOLDOFF_TICKS clken ticks after the last pulse.
- AUTO=1, idle; change value to 0xFFFFFFFF -> a sequence starts within 2 clk; all 8 data bytes are 0x4E.
- dp=0x81, blank=0x18, value=0x88888888 -> data FF,7F,7F,00,00,7F,7F,FF.
- Change value every clk for 3 holdoff periods -> exactly one sequence per holdoff period; each sequence is internally consistent with a single snapshot.
- AUTO=0: pulse update 3 times during HOLD -> exactly one further sequence after HOLD expires; with no update, an input change causes no wr.
- Assert reset at the 4th wr pulse -> wr/mask/data/busy go to 0 at once; after release, a full 8-pulse sequence begins with mask 0x80.
